// File: rtl/coh_bus_pkg.sv
// Purpose : shared types and helpers for the snooping coherence bus controller.
// Latency : n/a (types only).
// Backpressure: n/a.
package coh_bus_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SNOOP    = 3'd1,
    COPYBACK = 3'd2,
    MEM_RD   = 3'd3,
    RESP     = 3'd4
  } state_t;

  typedef enum logic {
    BUS_RD  = 1'b0,
    BUS_RDX = 1'b1
  } bus_op_t;

  // Width of a core index; never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/coherence_bus_ctrl_rr_arbiter.sv
// Purpose : combinational round-robin pick of the first requester at or after ptr.
// Latency : 0 cycles (pure combinational).
// Backpressure: none; the caller decides when to consume gnt/idx.
// Ports   : req (request vector), ptr (priority start index),
//           gnt (one-hot grant), idx (granted index), gnt_vld (any request).
module rr_arbiter
  import coh_bus_pkg::*;
#(
  parameter int NUM_CORES = 4,
  parameter int IDX_W     = idx_width(NUM_CORES)
) (
  input  logic [NUM_CORES-1:0] req,
  input  logic [IDX_W-1:0]     ptr,
  output logic [NUM_CORES-1:0] gnt,
  output logic [IDX_W-1:0]     idx,
  output logic                 gnt_vld
);

  int best;
  int best_d;
  int d;

  // Distance from ptr (modulo NUM_CORES) ranks the requesters; smallest wins.
  always_comb begin
    best   = 0;
    best_d = NUM_CORES;
    d      = 0;
    for (int i = 0; i < NUM_CORES; i++) begin
      d = (i >= int'(ptr)) ? (i - int'(ptr)) : (i + NUM_CORES - int'(ptr));
      if (req[i] && (d < best_d)) begin
        best_d = d;
        best   = i;
      end
    end
    gnt     = '0;
    gnt_vld = (best_d < NUM_CORES);
    idx     = IDX_W'(best);
    for (int i = 0; i < NUM_CORES; i++) begin
      if (gnt_vld && (i == best)) gnt[i] = 1'b1;
    end
  end

endmodule

// File: rtl/coherence_bus_ctrl.sv
// Purpose : snooping-bus controller; arbitrates core misses/upgrades, snoops, then copy-back or memory read.
// Latency : request seen cycle 0, snoop cycle 1, memory/copy-back cycle 2+, resp_valid one cycle after mem_ready.
// Backpressure: mem_ready stalls COPYBACK/MEM_RD; requests are level and wait in IDLE until granted.
// Ports   : rd_intent/wr_intent/req_addr per-core requests; snoop_* per-core replies; mem_* main memory;
//           grant/snoop_valid/bus_addr/bus_wr_intent broadcast; resp_valid/resp_data/ex_or_shared to requester.
module coherence_bus_ctrl
  import coh_bus_pkg::*;
#(
  parameter int NUM_CORES = 4,
  parameter int ADDR_W    = 5,
  parameter int DATA_W    = 32
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_CORES-1:0]        rd_intent,
  input  logic [NUM_CORES-1:0]        wr_intent,
  input  logic [NUM_CORES*ADDR_W-1:0] req_addr,
  input  logic [NUM_CORES-1:0]        snoop_hit,
  input  logic [NUM_CORES-1:0]        snoop_dirty,
  input  logic [NUM_CORES*DATA_W-1:0] snoop_data,
  input  logic [DATA_W-1:0]           mem_rdata,
  input  logic                        mem_ready,
  output logic [NUM_CORES-1:0]        grant,
  output logic                        snoop_valid,
  output logic [ADDR_W-1:0]           bus_addr,
  output logic                        bus_wr_intent,
  output logic                        mem_rd,
  output logic                        main_mem_wr,
  output logic [DATA_W-1:0]           mem_wdata,
  output logic [NUM_CORES-1:0]        resp_valid,
  output logic [DATA_W-1:0]           resp_data,
  output logic                        ex_or_shared
);

  localparam int IDX_W = idx_width(NUM_CORES);

  state_t                 state, state_nxt;
  bus_op_t                bus_op;
  logic [IDX_W-1:0]       rr_ptr, gnt_idx, arb_idx;
  logic [NUM_CORES-1:0]   req, arb_gnt, masked_hit, masked_dirty;
  logic                   arb_vld, other_hit, any_dirty;
  logic [ADDR_W-1:0]      sel_addr;
  logic [DATA_W-1:0]      owner_data;

  assign req = rd_intent | wr_intent;

  rr_arbiter #(.NUM_CORES(NUM_CORES), .IDX_W(IDX_W)) u_arb (
    .req     (req),
    .ptr     (rr_ptr),
    .gnt     (arb_gnt),
    .idx     (arb_idx),
    .gnt_vld (arb_vld)
  );

  // The requester's own snoop reply is ignored.
  assign masked_hit   = snoop_hit & ~grant;
  assign masked_dirty = snoop_dirty & ~grant;
  assign any_dirty    = |masked_dirty;
  assign bus_wr_intent = (bus_op == BUS_RDX);

  always_comb begin
    sel_addr = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      if (IDX_W'(i) == arb_idx) sel_addr = req_addr[i*ADDR_W +: ADDR_W];
    end
  end

  // Descending scan so the lowest-index dirty owner ends up selected.
  always_comb begin
    owner_data = '0;
    for (int i = NUM_CORES - 1; i >= 0; i--) begin
      if (masked_dirty[i]) owner_data = snoop_data[i*DATA_W +: DATA_W];
    end
  end

  always_comb begin
    state_nxt    = state;
    snoop_valid  = 1'b0;
    mem_rd       = 1'b0;
    main_mem_wr  = 1'b0;
    resp_valid   = '0;
    ex_or_shared = 1'b0;
    case (state)
      IDLE:     if (arb_vld) state_nxt = SNOOP;
      SNOOP: begin
        snoop_valid = 1'b1;
        state_nxt   = any_dirty ? COPYBACK : MEM_RD;
      end
      COPYBACK: begin
        main_mem_wr = 1'b1;
        if (mem_ready) state_nxt = RESP;
      end
      MEM_RD: begin
        mem_rd = 1'b1;
        if (mem_ready) state_nxt = RESP;
      end
      RESP: begin
        resp_valid   = grant;
        ex_or_shared = bus_wr_intent | ~other_hit;
        state_nxt    = IDLE;
      end
      default:  state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      gnt_idx   <= '0;
      grant     <= '0;
      bus_addr  <= '0;
      bus_op    <= BUS_RD;
      other_hit <= 1'b0;
      mem_wdata <= '0;
      resp_data <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (arb_vld) begin
            grant    <= arb_gnt;
            gnt_idx  <= arb_idx;
            bus_addr <= sel_addr;
            // A core asserting both intents is treated as an upgrade.
            bus_op   <= (|(wr_intent & arb_gnt)) ? BUS_RDX : BUS_RD;
          end
        end
        SNOOP: begin
          other_hit <= |masked_hit;
          if (any_dirty) begin
            mem_wdata <= owner_data;
            resp_data <= owner_data;
          end
        end
        MEM_RD: if (mem_ready) resp_data <= mem_rdata;
        RESP: begin
          rr_ptr <= (gnt_idx == IDX_W'(NUM_CORES - 1)) ? '0 : gnt_idx + IDX_W'(1);
          grant  <= '0;
        end
        default: ;
      endcase
    end
  end

  // Two modified copies of one line means the protocol has already broken down.
  a_single_owner: assert property (@(posedge clk) disable iff (reset)
    (state == SNOOP) |-> $onehot0(snoop_dirty & ~grant));

endmodule

// File: tb/tb_coherence_bus_ctrl.sv
module tb_coherence_bus_ctrl;

  localparam int NC = 4;
  localparam int AW = 5;
  localparam int DW = 32;

  logic              clk = 1'b0;
  logic              reset;
  logic [NC-1:0]     rd_intent, wr_intent, snoop_hit, snoop_dirty;
  logic [NC*AW-1:0]  req_addr;
  logic [NC*DW-1:0]  snoop_data;
  logic [DW-1:0]     mem_rdata;
  logic              mem_ready;
  logic [NC-1:0]     grant, resp_valid;
  logic              snoop_valid, bus_wr_intent, mem_rd, main_mem_wr, ex_or_shared;
  logic [AW-1:0]     bus_addr;
  logic [DW-1:0]     mem_wdata, resp_data;

  int total = 0;
  int bad   = 0;
  int cnt;
  logic [NC-1:0] exp_order [5];

  coherence_bus_ctrl #(.NUM_CORES(NC), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk           (clk),
    .reset         (reset),
    .rd_intent     (rd_intent),
    .wr_intent     (wr_intent),
    .req_addr      (req_addr),
    .snoop_hit     (snoop_hit),
    .snoop_dirty   (snoop_dirty),
    .snoop_data    (snoop_data),
    .mem_rdata     (mem_rdata),
    .mem_ready     (mem_ready),
    .grant         (grant),
    .snoop_valid   (snoop_valid),
    .bus_addr      (bus_addr),
    .bus_wr_intent (bus_wr_intent),
    .mem_rd        (mem_rd),
    .main_mem_wr   (main_mem_wr),
    .mem_wdata     (mem_wdata),
    .resp_valid    (resp_valid),
    .resp_data     (resp_data),
    .ex_or_shared  (ex_or_shared)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Bounded wait for the next completion pulse.
  task automatic wait_resp();
    for (int n = 0; n < 12; n++) begin
      tick();
      if (resp_valid != '0) break;
    end
  endtask

  task automatic clear_inputs();
    rd_intent   = '0;
    wr_intent   = '0;
    snoop_hit   = '0;
    snoop_dirty = '0;
    snoop_data  = '0;
  endtask

  initial begin
    reset     = 1'b1;
    req_addr  = '0;
    mem_rdata = '0;
    mem_ready = 1'b1;
    clear_inputs();
    exp_order[0] = 4'b0001; exp_order[1] = 4'b0010; exp_order[2] = 4'b0100;
    exp_order[3] = 4'b1000; exp_order[4] = 4'b0001;

    // Reset state
    tick(); tick();
    chk("rst_grant", grant, 0);
    chk("rst_ctrl", {snoop_valid, bus_wr_intent, mem_rd, main_mem_wr, ex_or_shared}, 0);
    chk("rst_addr_resp", {bus_addr, resp_valid}, 0);
    chk("rst_data", {mem_wdata, resp_data}, 0);
    reset = 1'b0;
    tick(); tick();
    chk("idle_quiet", {grant, snoop_valid}, 0);

    // 1: core1 read miss, only its own (masked) snoop reply -> memory read, exclusive
    rd_intent = 4'b0010;
    req_addr[1*AW +: AW] = 5'h0A;
    snoop_hit = 4'b0010;
    snoop_dirty = 4'b0010;
    mem_rdata = 32'h1234_5678;
    chk("t1_c0_grant", grant, 0);
    tick();
    chk("t1_snoop", {snoop_valid, grant}, {1'b1, 4'b0010});
    chk("t1_addr_op", {bus_addr, bus_wr_intent}, {5'h0A, 1'b0});
    tick();
    chk("t1_memrd", {mem_rd, main_mem_wr}, 2'b10);
    tick();
    chk("t1_resp", resp_valid, 4'b0010);
    chk("t1_ex", ex_or_shared, 1);
    chk("t1_data", resp_data, 32'h1234_5678);
    clear_inputs();
    tick();
    chk("t1_after", {grant, resp_valid}, 0);

    // 2: core0 read, core2 holds clean copy -> shared
    rd_intent = 4'b0001;
    req_addr[0 +: AW] = 5'h03;
    snoop_hit = 4'b0100;
    mem_rdata = 32'hA5A5_0003;
    tick();
    chk("t2_grant", grant, 4'b0001);
    chk("t2_addr_op", {bus_addr, bus_wr_intent}, {5'h03, 1'b0});
    tick(); tick();
    chk("t2_resp", resp_valid, 4'b0001);
    chk("t2_shared", ex_or_shared, 0);
    chk("t2_data", resp_data, 32'hA5A5_0003);
    clear_inputs();
    tick();

    // 3: core3 write, core1 dirty owner -> copy-back, no memory read
    wr_intent = 4'b1000;
    req_addr[3*AW +: AW] = 5'h11;
    snoop_hit = 4'b0010;
    snoop_dirty = 4'b0010;
    snoop_data[1*DW +: DW] = 32'hDEAD_BEEF;
    mem_rdata = 32'h1111_1111;
    tick();
    chk("t3_grant", grant, 4'b1000);
    chk("t3_addr_op", {bus_addr, bus_wr_intent}, {5'h11, 1'b1});
    tick();
    chk("t3_cpb", {mem_rd, main_mem_wr}, 2'b01);
    chk("t3_wdata", mem_wdata, 32'hDEAD_BEEF);
    tick();
    chk("t3_resp", {resp_valid, mem_rd}, {4'b1000, 1'b0});
    chk("t3_data", resp_data, 32'hDEAD_BEEF);
    chk("t3_ex", ex_or_shared, 1);
    clear_inputs();
    tick();

    // 4: all cores requesting continuously -> round-robin order 0,1,2,3,0
    rd_intent = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      wait_resp();
      chk("t4_order", resp_valid, exp_order[k]);
    end
    clear_inputs();
    tick();

    // 5: memory stalls 5 cycles; core2 asserts both intents (treated as upgrade)
    rd_intent = 4'b0100;
    wr_intent = 4'b0100;
    req_addr[2*AW +: AW] = 5'h07;
    mem_ready = 1'b0;
    mem_rdata = 32'hFFFF_0000;
    tick();
    chk("t5_grant", grant, 4'b0100);
    chk("t5_rdx", bus_wr_intent, 1);
    tick();
    cnt = 0;
    for (int k = 0; k < 5; k++) begin
      chk("t5_stall", {grant, resp_valid}, {4'b0100, 4'b0000});
      if (mem_rd) cnt++;
      tick();
    end
    mem_ready = 1'b1;
    mem_rdata = 32'hCAFE_F00D;
    if (mem_rd) cnt++;
    tick();
    chk("t5_rd_cycles", cnt, 6);
    chk("t5_resp", resp_valid, 4'b0100);
    chk("t5_data", resp_data, 32'hCAFE_F00D);
    clear_inputs();
    tick();

    // 6: reset during copy-back aborts; pointer restarts at core0
    wr_intent = 4'b0010;
    snoop_dirty = 4'b0100;
    snoop_data[2*DW +: DW] = 32'h55AA_55AA;
    mem_ready = 1'b0;
    tick(); tick();
    chk("t6_cpb", {main_mem_wr, mem_wdata}, {1'b1, 32'h55AA_55AA});
    reset = 1'b1;
    tick();
    chk("t6_rst_grant", {grant, resp_valid}, 0);
    chk("t6_rst_ctrl", {snoop_valid, bus_wr_intent, mem_rd, main_mem_wr, ex_or_shared}, 0);
    chk("t6_rst_data", {mem_wdata, resp_data}, 0);
    reset = 1'b0;
    clear_inputs();
    rd_intent = 4'b1001;
    mem_ready = 1'b1;
    tick();
    chk("t6_first_grant", grant, 4'b0001);
    tick(); tick();
    chk("t6_resp", resp_valid, 4'b0001);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
